uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NUM_REQ byte producers using round-robin arbitration. Sequences the transmitter: issues the one-cycle tx_start with the latched byte, then waits for tx_done_tick before granting again. Supports multi-byte packet locking, so a requester keeps the line until it marks its last byte, with a watchdog on stalled packets. Sits between the system-side producers (command/status/debug streams) and uart_tx.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BITWIDTH, 8, byte width; must match uart_tx
HOLD_TIMEOUT, 1024, clk cycles a locked requester may idle before the lock is forcibly released
GNT_W (local), $clog2(NUM_REQ), grant index width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*BITWIDTH  flattened bytes; requester i occupies bits [i*BITWIDTH +: BITWIDTH]
req_last  in  NUM_REQ  byte is last of packet; releases lock after transmission
req_ready  out  NUM_REQ  one-hot accept pulse; byte i transferred when req_valid[i]&req_ready[i]
done_tick  out  NUM_REQ  one-hot pulse when requester's byte has finished on the line
tx_start  out  1  one-cycle start strobe to uart_tx
tx_din  out  BITWIDTH  byte to uart_tx, stable from the tx_start cycle until tx_done_tick
tx_done_tick  in  1  completion pulse from uart_tx
busy  out  1  high in any state other than IDLE
grant_id  out  GNT_W  current/last granted requester index
timeout_err  out  1  one-cycle pulse when a lock is released by the watchdog

Behaviour:
- Reset (synchronous, reset=1 at clk edge): state=IDLE, rr_ptr=0, grant_id=0, tx_din=0, lock=0, hold counter=0. All of tx_start, req_ready, done_tick, timeout_err, busy are 0. Reset wins over every other event, including mid-byte. In-flight bytes are abandoned with no done_tick.
- States: IDLE, START, WAIT_DONE, HOLD.
- IDLE: when any req_valid is set, pick g = first set bit scanning from rr_ptr upward with wrap. In the same cycle, drive req_ready[g]=1 combinationally, register tx_din<=req_data[g], grant_id<=g, lock<=~req_last[g], and go to START. If no request is valid, stay in IDLE.
- START: tx_start=1 for exactly this one cycle, then go to WAIT_DONE. Latency from the accept cycle to tx_start is 1 clk.
- WAIT_DONE: hold tx_din. On tx_done_tick, pulse done_tick[grant_id] in the same cycle.
  - If lock=1, go to HOLD and clear the hold counter.
  - If lock=0, set rr_ptr<=(grant_id+1) mod NUM_REQ and go to IDLE.
  - tx_done_tick in any other state is ignored.
- HOLD: only requester grant_id is eligible; all others wait.
  - If req_valid[grant_id]: drive req_ready[grant_id]=1, latch the byte, set lock<=~req_last[grant_id], go to START.
  - Otherwise, increment the hold counter. When it reaches HOLD_TIMEOUT-1, pulse timeout_err, clear lock, set rr_ptr<=grant_id+1, and go to IDLE.
- Fairness: after an unlocked completion the next scan starts at grant_id+1. Wrap from NUM_REQ-1 goes to 0.
- Simultaneous events:
  - req_valid changes during START/WAIT_DONE have no effect; requesters must hold valid until ready.
  - req_ready is never asserted outside the IDLE/HOLD accept cycle and is at most one-hot.
- Back-to-back: the minimum gap between tx_done_tick and the next tx_start is 2 clk (accept cycle + START). This satisfies uart_tx's return to idle.
- Counter width: $clog2(HOLD_TIMEOUT+1), saturating. HOLD_TIMEOUT=0 is illegal.

Decomposition:
- Shared package uart_pkg holds:
  - the arbiter state encoding (2-bit: IDLE=0, START=1, WAIT_DONE=2, HOLD=3)
  - the BITWIDTH and SB_TICK defaults, shared with uart_tx/uart_rx
- One combinational sub-module, uart_rr_pick(req, ptr → gnt_onehot, gnt_idx, any). It is reused by the future rx-side distributor.

Test Plan:
- Single request: req_valid=4'b0010, data[1]=8'hA5, last=1 → req_ready=4'b0010 one cycle, tx_start 1 clk later with tx_din=8'hA5, done_tick=4'b0010 on tx_done_tick, rr_ptr=2.
- Simultaneous: all 4 valid with last=1, bytes 8'h10/11/12/13 → transmit order 0,1,2,3. With requester 0 re-requesting, order continues 0,1,2,3 (no starvation).
- Packet lock: req 2 sends 3 bytes (last only on the third) while req 0 is valid → bytes of req 2 are transmitted contiguously, then req 0. grant_id stays 2 across all three tx_start strobes.
- Hold timeout (HOLD_TIMEOUT=8): req 1 sends byte with last=0 then drops valid → timeout_err pulses 8 cycles after entering HOLD, state returns to IDLE, a pending req 2 is granted next.
- Reset mid-frame: assert reset in WAIT_DONE → next cycle busy=0, tx_start=0, grant_id=0, no done_tick. A later request from req 3 is granted normally.
- Stray done: tx_done_tick pulsed in IDLE with no requests → no done_tick, state unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the byte/oversampling
// defaults that uart_tx, uart_rx and the arbiters agree on.
package uart_pkg;

   localparam int DEF_BITWIDTH = 8;
   localparam int DEF_SB_TICK  = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      HOLD      = 2'd3
   } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: finds the first set request bit scanning upward from
// ptr with wrap-around. Purely combinational.
module uart_rr_pick #(
   parameter int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt_onehot,
   output logic [W-1:0] gnt_idx,
   output logic         any
);

   always_comb begin
      int j;
      j          = 0;
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any           = 1'b1;
            gnt_onehot[j] = 1'b1;
            gnt_idx       = W'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers with round-robin
// arbitration, multi-byte packet locking and a watchdog on stalled packets.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int BITWIDTH     = DEF_BITWIDTH,
   parameter int HOLD_TIMEOUT = 1024,
   localparam int GNT_W = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*BITWIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            done_tick,
   output logic                          tx_start,
   output logic [BITWIDTH-1:0]           tx_din,
   input  logic                          tx_done_tick,
   output logic                          busy,
   output logic [GNT_W-1:0]              grant_id,
   output logic                          timeout_err
);

   localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   arb_state_t          state, state_n;
   logic [GNT_W-1:0]    rr_ptr, rr_ptr_n;
   logic [GNT_W-1:0]    grant_n;
   logic [BITWIDTH-1:0] din_n;
   logic                lock, lock_n;
   logic [CNT_W-1:0]    hold_cnt, cnt_n;

   logic [BITWIDTH-1:0] req_bytes [NUM_REQ];
   logic [NUM_REQ-1:0]  pick_onehot;
   logic [GNT_W-1:0]    pick_idx;
   logic                pick_any;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_bytes[i] = req_data[i*BITWIDTH +: BITWIDTH];
   end

   uart_rr_pick #(.N(NUM_REQ)) u_pick (
      .req        (req_valid),
      .ptr        (rr_ptr),
      .gnt_onehot (pick_onehot),
      .gnt_idx    (pick_idx),
      .any        (pick_any)
   );

   function automatic logic [GNT_W-1:0] next_idx(input logic [GNT_W-1:0] g);
      return (int'(g) == NUM_REQ - 1) ? '0 : g + GNT_W'(1);
   endfunction

   assign tx_start = (state == START);
   assign busy     = (state != IDLE);

   always_comb begin
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      grant_n     = grant_id;
      din_n       = tx_din;
      lock_n      = lock;
      cnt_n       = hold_cnt;
      req_ready   = '0;
      done_tick   = '0;
      timeout_err = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               req_ready = pick_onehot;
               din_n     = req_bytes[pick_idx];
               grant_n   = pick_idx;
               lock_n    = ~req_last[pick_idx];
               state_n   = START;
            end
         end
         START: state_n = WAIT_DONE;
         WAIT_DONE: begin
            if (tx_done_tick) begin
               done_tick[grant_id] = 1'b1;
               if (lock) begin
                  cnt_n   = '0;
                  state_n = HOLD;
               end else begin
                  rr_ptr_n = next_idx(grant_id);
                  state_n  = IDLE;
               end
            end
         end
         HOLD: begin
            // Only the lock owner may continue; everyone else waits for release.
            if (req_valid[grant_id]) begin
               req_ready[grant_id] = 1'b1;
               din_n               = req_bytes[grant_id];
               lock_n              = ~req_last[grant_id];
               state_n             = START;
            end else if (hold_cnt == CNT_LAST) begin
               timeout_err = 1'b1;
               lock_n      = 1'b0;
               rr_ptr_n    = next_idx(grant_id);
               state_n     = IDLE;
            end else if (hold_cnt != CNT_MAX) begin
               cnt_n = hold_cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         tx_din   <= '0;
         lock     <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_ptr_n;
         grant_id <= grant_n;
         tx_din   <= din_n;
         lock     <= lock_n;
         hold_cnt <= cnt_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a per-cycle vector table, hand-built packet
// sequences and randomized packet streams checked against a packet-level model.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int BW = 8;
   localparam int HT = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*BW-1:0]  req_data = '0;
   logic [NR-1:0]     req_last = '0;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     done_tick;
   logic              tx_start;
   logic [BW-1:0]     tx_din;
   logic              tx_done_tick = 1'b0;
   logic              busy;
   logic [1:0]        grant_id;
   logic              timeout_err;

   uart_tx_arbiter #(.NUM_REQ(NR), .BITWIDTH(BW), .HOLD_TIMEOUT(HT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .done_tick    (done_tick),
      .tx_start     (tx_start),
      .tx_din       (tx_din),
      .tx_done_tick (tx_done_tick),
      .busy         (busy),
      .grant_id     (grant_id),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int vec_count  = 0;
   int fail_count = 0;

   typedef struct {
      logic          rst;
      logic [NR-1:0] valid;
      logic [31:0]   data;
      logic [NR-1:0] last;
      logic          done;
      logic [NR-1:0] e_ready;
      logic          e_start;
      logic [7:0]    e_din;
      logic [NR-1:0] e_dtick;
      logic          e_busy;
      logic [1:0]    e_gid;
      logic          e_terr;
   } vec_t;

   vec_t vecs [18];

   // Packet-driven producers, a fake uart_tx, and the expected transmit order.
   bit [8:0]  pq [NR][$];
   bit [8:0]  mq [NR][$];
   bit [9:0]  expq [$];
   int        done_cyc [$];
   bit [NR-1:0] acc;
   bit        auto_mode;
   bit        have_inflight;
   bit [1:0]  inflight_gid;
   bit [7:0]  inflight_byte;
   int        uart_cnt, dly_max, cyc, start_count, terr_cnt, terr_cyc;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset        = v.rst;
      req_valid    = v.valid;
      req_data     = v.data;
      req_last     = v.last;
      tx_done_tick = v.done;
   endtask

   task automatic do_reset();
      auto_mode = 1'b0;
      reset = 1'b1;
      req_valid = '0; req_data = '0; req_last = '0; tx_done_tick = 1'b0;
      for (int i = 0; i < NR; i++) begin pq[i].delete(); mq[i].delete(); end
      expq.delete(); done_cyc.delete();
      acc = '0; have_inflight = 1'b0; uart_cnt = 0;
      start_count = 0; terr_cnt = 0; terr_cyc = 0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic drive_bus();
      tx_done_tick = 1'b0;
      if (uart_cnt > 0) begin
         uart_cnt--;
         if (uart_cnt == 0) tx_done_tick = 1'b1;
      end
      for (int i = 0; i < NR; i++) begin
         if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
         req_valid[i]        = (pq[i].size() != 0);
         req_data[i*BW +: BW] = req_valid[i] ? pq[i][0][7:0] : 8'h00;
         req_last[i]         = req_valid[i] ? pq[i][0][8] : 1'b0;
      end
      acc = '0;
   endtask

   task automatic monitor();
      bit [9:0] e;
      cyc++;
      acc = req_valid & req_ready;
      if (req_ready != '0)
         checkOutput("ready_legal", 32'(((req_ready & ~req_valid) == '0) && ($countones(req_ready) == 1)), 32'd1);
      if (tx_start) begin
         start_count++;
         if (expq.size() == 0) begin
            checkOutput("unexpected_start", {22'd0, grant_id, tx_din}, 32'h3ff);
         end else begin
            e = expq.pop_front();
            checkOutput("start_gid_byte", {22'd0, grant_id, tx_din}, {22'd0, e});
            have_inflight = 1'b1;
            inflight_gid  = e[9:8];
            inflight_byte = e[7:0];
            uart_cnt      = $urandom_range(1, dly_max);
         end
      end
      if (tx_done_tick) begin
         done_cyc.push_back(cyc);
         if (have_inflight) begin
            checkOutput("done_tick", 32'(done_tick), 32'(4'b0001 << inflight_gid));
            checkOutput("din_hold", 32'(tx_din), 32'(inflight_byte));
            have_inflight = 1'b0;
         end else begin
            checkOutput("stray_done", 32'(done_tick), 32'd0);
         end
      end
      if (timeout_err) begin
         terr_cnt++;
         terr_cyc = cyc;
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
      if (auto_mode) drive_bus();
      @(negedge clk);
      if (auto_mode) monitor();
   endtask

   task automatic wait_start();
      int s0;
      s0 = start_count;
      for (int c = 0; c < 100 && start_count == s0; c++) tick();
      checkOutput("wait_start", 32'(start_count > s0), 32'd1);
   endtask

   task automatic run_drain(input string name, input int max_cycles);
      bit drained;
      drained = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         if (expq.size() == 0 && !have_inflight && !busy) begin
            drained = 1'b1;
            break;
         end
         tick();
      end
      checkOutput({name, "_drained"}, 32'(drained), 32'd1);
      for (int c = 0; c < 4; c++) tick();
   endtask

   // Packet-level round robin: whole packets go out in order, scanning from
   // the requester after the last one served.
   task automatic build_random();
      int ptr, g, np, len, guard;
      bit found;
      bit [8:0] e;
      for (int i = 0; i < NR; i++) begin
         np = $urandom_range(0, 3);
         for (int p = 0; p < np; p++) begin
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
               e = {(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))};
               pq[i].push_back(e);
               mq[i].push_back(e);
            end
         end
      end
      ptr = 0;
      for (guard = 0; guard < 100; guard++) begin
         found = 1'b0;
         g = 0;
         for (int k = 0; k < NR; k++) begin
            if (!found && mq[(ptr + k) % NR].size() > 0) begin
               found = 1'b1;
               g = (ptr + k) % NR;
            end
         end
         if (!found) break;
         do begin
            e = mq[g].pop_front();
            expq.push_back({2'(g), e[7:0]});
         end while (!e[8] && mq[g].size() > 0);
         ptr = (g + 1) % NR;
      end
   endtask

   initial begin
      // rst valid  data          last   done | ready start din   dtick busy gid terr
      vecs[0]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[2]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[3]  = '{1'b0, 4'b0010, 32'h0000_A500, 4'b0010, 1'b0, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[4]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 4'b0000, 1'b1, 2'd1, 1'b0};
      vecs[5]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 4'b0000, 1'b1, 2'd1, 1'b0};
      vecs[6]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 4'b0000, 1'b1, 2'd1, 1'b0};
      vecs[7]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 4'b0010, 1'b1, 2'd1, 1'b0};
      vecs[8]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 4'b0000, 1'b0, 2'd1, 1'b0};
      vecs[9]  = '{1'b0, 4'b0110, 32'h0032_3100, 4'b0110, 1'b0, 4'b0100, 1'b0, 8'hA5, 4'b0000, 1'b0, 2'd1, 1'b0};
      vecs[10] = '{1'b0, 4'b0010, 32'h0032_3100, 4'b0110, 1'b0, 4'b0000, 1'b1, 8'h32, 4'b0000, 1'b1, 2'd2, 1'b0};
      vecs[11] = '{1'b0, 4'b0010, 32'h0032_3100, 4'b0110, 1'b0, 4'b0000, 1'b0, 8'h32, 4'b0000, 1'b1, 2'd2, 1'b0};
      vecs[12] = '{1'b1, 4'b0010, 32'h0032_3100, 4'b0110, 1'b0, 4'b0000, 1'b0, 8'h32, 4'b0000, 1'b1, 2'd2, 1'b0};
      vecs[13] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[14] = '{1'b0, 4'b1000, 32'h5A00_0000, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[15] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h5A, 4'b0000, 1'b1, 2'd3, 1'b0};
      vecs[16] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h5A, 4'b1000, 1'b1, 2'd3, 1'b0};
      vecs[17] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h5A, 4'b0000, 1'b0, 2'd3, 1'b0};

      cyc = 0;
      dly_max = 1;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i),
                     32'({req_ready, tx_start, tx_din, done_tick, busy, grant_id, timeout_err}),
                     32'({vecs[i].e_ready, vecs[i].e_start, vecs[i].e_din, vecs[i].e_dtick,
                          vecs[i].e_busy, vecs[i].e_gid, vecs[i].e_terr}));
      end

      // All four requesters at once, requester 0 queues a second byte.
      do_reset();
      dly_max = 3;
      pq[0].push_back(9'h110); pq[0].push_back(9'h120);
      pq[1].push_back(9'h111); pq[2].push_back(9'h112); pq[3].push_back(9'h113);
      expq.push_back({2'd0, 8'h10}); expq.push_back({2'd1, 8'h11});
      expq.push_back({2'd2, 8'h12}); expq.push_back({2'd3, 8'h13});
      expq.push_back({2'd0, 8'h20});
      auto_mode = 1'b1;
      run_drain("simultaneous", 300);
      checkOutput("simultaneous_no_timeout", 32'(terr_cnt), 32'd0);

      // Requester 2 locks the line for a 3-byte packet while requester 0 waits.
      do_reset();
      dly_max = 4;
      pq[2].push_back(9'h040); pq[2].push_back(9'h041); pq[2].push_back(9'h142);
      expq.push_back({2'd2, 8'h40}); expq.push_back({2'd2, 8'h41});
      expq.push_back({2'd2, 8'h42}); expq.push_back({2'd0, 8'h50});
      auto_mode = 1'b1;
      wait_start();
      pq[0].push_back(9'h150);
      run_drain("packet_lock", 300);
      checkOutput("lock_no_timeout", 32'(terr_cnt), 32'd0);

      // Requester 1 opens a packet and stalls; the watchdog must free the line.
      do_reset();
      dly_max = 2;
      pq[1].push_back(9'h061);
      expq.push_back({2'd1, 8'h61}); expq.push_back({2'd2, 8'h62});
      auto_mode = 1'b1;
      wait_start();
      pq[2].push_back(9'h162);
      run_drain("hold_timeout", 300);
      checkOutput("timeout_count", 32'(terr_cnt), 32'd1);
      checkOutput("timeout_cycle", 32'(terr_cyc - ((done_cyc.size() > 0) ? done_cyc[0] : 0)), 32'(HT));

      for (int r = 0; r < 6; r++) begin
         do_reset();
         dly_max = $urandom_range(1, 5);
         build_random();
         auto_mode = 1'b1;
         run_drain($sformatf("random%0d", r), 3000);
         checkOutput($sformatf("random%0d_no_timeout", r), 32'(terr_cnt), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

endmodule
